// File: rtl/spi_shift_master.sv
// SPI master for the serial shift-register chain: shifts an N-bit word out MSB first and captures N bits back.
// Latency: done pulses HALF*(2N+2) clk cycles after the accepting edge; all outputs are registered.
// Backpressure: start is sampled only while idle; start, tx_data and miso outside their sample points are ignored.
//
// Ports:
//   clk      system clock, all logic on its rising edge
//   nreset   synchronous active-low reset; aborts a transfer without a done pulse
//   start    transfer request, accepted only while busy is low
//   tx_data  word to send, captured on the accepting edge
//   busy     high from the accepting edge until the done edge
//   done     single-cycle pulse marking the end of a transfer
//   rx_data  last received word, updated only together with done
//   spi_clk  serial clock, idles low
//   mosi     serial data out, launched on spi_clk rising
//   miso     serial data in, sampled on spi_clk falling
//   cs_n     active-low transfer frame

module spi_shift_master #(
   parameter int N    = 8,   // transfer width in bits, at least 2
   parameter int HALF = 4    // clk cycles per spi_clk half-period, at least 4
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         start,
   input  logic [N-1:0] tx_data,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] rx_data,
   output logic         spi_clk,
   output logic         mosi,
   input  logic         miso,
   output logic         cs_n
);

   localparam int PW = $clog2(HALF);
   localparam int BW = $clog2(N);

   localparam logic [PW-1:0] PHASE_LAST = PW'(HALF - 1);
   localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);
   localparam logic [BW-1:0] BIT_ONE    = BW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_HOLD
   } state_t;

   state_t         state_q,    state_d;
   logic [PW-1:0]  phase_q,    phase_d;
   logic [BW-1:0]  bit_q,      bit_d;
   logic [N-1:0]   tx_shift_q, tx_shift_d;
   logic [N-1:0]   rx_shift_q, rx_shift_d;
   logic [N-1:0]   rx_data_q,  rx_data_d;
   logic           spi_clk_q,  spi_clk_d;
   logic           mosi_q,     mosi_d;
   logic           cs_n_q,     cs_n_d;
   logic           busy_q,     busy_d;
   logic           done_q,     done_d;

   logic           phase_last;

   // Every non-idle state lasts exactly HALF cycles; the counter restarts on each transition.
   assign phase_last = (phase_q == PHASE_LAST);

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         bit_q      <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         spi_clk_q  <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         spi_clk_q  <= spi_clk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q + PHASE_ONE;
      bit_d      = bit_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      spi_clk_d  = spi_clk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            phase_d = '0;
            if (start) begin
               state_d    = S_SETUP;
               tx_shift_d = tx_data;
               rx_shift_d = '0;
               bit_d      = '0;
               busy_d     = 1'b1;
               cs_n_d     = 1'b0;
            end
         end

         // cs_n setup time before the first rising edge.
         S_SETUP: begin
            if (phase_last) begin
               state_d   = S_HIGH;
               phase_d   = '0;
               spi_clk_d = 1'b1;
               mosi_d    = tx_shift_q[N-1];
            end
         end

         // Falling edge: the chain had a full half-period after the rising
         // edge to update miso, so the value present now is the settled bit.
         S_HIGH: begin
            if (phase_last) begin
               state_d    = S_LOW;
               phase_d    = '0;
               spi_clk_d  = 1'b0;
               rx_shift_d = {rx_shift_q[N-2:0], miso};
            end
         end

         // mosi is held through LOW so a synchronised receiver sees it
         // stable well after the falling edge. The next bit is launched from
         // tx_shift_q[N-2] because the shift happens on this same edge.
         S_LOW: begin
            if (phase_last) begin
               phase_d    = '0;
               tx_shift_d = {tx_shift_q[N-2:0], 1'b0};
               bit_d      = bit_q + BIT_ONE;
               if (bit_q == BIT_LAST) begin
                  state_d = S_HOLD;
               end else begin
                  state_d   = S_HIGH;
                  spi_clk_d = 1'b1;
                  mosi_d    = tx_shift_q[N-2];
               end
            end
         end

         // cs_n hold time after the last falling edge, then close the frame.
         S_HOLD: begin
            if (phase_last) begin
               state_d   = S_IDLE;
               phase_d   = '0;
               cs_n_d    = 1'b1;
               mosi_d    = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_shift_q;
            end
         end

         default: begin
            state_d   = S_IDLE;
            phase_d   = '0;
            spi_clk_d = 1'b0;
            mosi_d    = 1'b0;
            cs_n_d    = 1'b1;
            busy_d    = 1'b0;
         end
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign spi_clk = spi_clk_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;

endmodule

// File: doc/spi_shift_master.md
# spi_shift_master

Clock-domain-safe SPI master that drives the MIDI switcher's serial shift-register chain (spi_clk, data out, data in) from the system clock. It accepts an N-bit word via a start/busy/done handshake and shifts it out MSB first. It simultaneously captures the N bits shifted back from the chain and frames each transfer with an active-low select. It sits directly upstream of the shift-register stage and produces exactly the edge ordering that stage expects: data launched on spi_clk rising, sampled on spi_clk falling, with spi_clk idling low.

## Interface
- N, 8, transfer width in bits (≥2)
- HALF, 4, clk cycles per spi_clk half-period (≥4, so a synchronising downstream stage can update its output before the master samples)

- clk  in  1  system clock; all logic on posedge
- nreset  in  1  synchronous, active-low reset
- start  in  1  request a transfer; sampled only when busy=0
- tx_data  in  N  word to send; captured on the accepting edge
- busy  out  1  high from the cycle after acceptance through the done cycle, exclusive
- done  out  1  one-cycle pulse at transfer end
- rx_data  out  N  last received word; updated only on done
- spi_clk  out  1  serial clock, idle 0
- mosi  out  1  serial data to the chain
- miso  in  1  serial data from the chain
- cs_n  out  1  transfer frame, active low

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD. A phase counter counts HALF cycles per state. A bit counter runs 0..N-1.
- IDLE: spi_clk=0, cs_n=1, mosi=0, busy=0. If start=1 at an edge: capture tx_data into the tx shift register, clear the bit counter, and go to SETUP. At that edge, set busy=1 and cs_n=0.
- SETUP (HALF cycles): cs_n=0, spi_clk=0. Exit to HIGH.
- Entry to HIGH (rising edge): spi_clk=1, mosi=tx_shift[N-1]. mosi holds through the following LOW.
- HIGH to LOW transition (falling edge): spi_clk=0. On the same clk edge, shift miso into the rx shift register LSB (MSB-first receive).
- End of LOW: shift tx_shift left and increment the bit counter. If the counter was N-1, go to HOLD; otherwise go to HIGH.
- HOLD (HALF cycles): spi_clk=0, cs_n=0. At exit: cs_n=1, mosi=0, busy=0, done=1, rx_data=rx_shift. Go to IDLE.
- Each transfer produces exactly N rising and N falling spi_clk edges.
- start while busy=1 is ignored. Changes to tx_data after acceptance are ignored. start held high through done starts a new transfer on the first edge after done (busy=0 at that sample).
- Reset (nreset=0 at any edge, including mid-transfer): state IDLE, spi_clk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, all counters and shift registers cleared. No done pulse is emitted for the aborted transfer.

## Timing
- Let E0 be the accepting edge. Then:
  - busy=1 and cs_n=0 from E0.
  - Bit i rising edge at E0+HALF·(1+2i).
  - Bit i falling edge (miso sample) at E0+HALF·(2+2i).
  - done, cs_n=1, busy=0 at E0+HALF·(2N+2). done drops one edge later.
- N=8, HALF=4: first rise at E0+4, last fall at E0+64, done at E0+72.
- miso is sampled HALF cycles after the corresponding rising edge. The sampled value is the one present in the cycle before the falling edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold nreset=0 for 3 cycles → spi_clk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0x00.
- Single transfer: behavioural synchronised slave preloaded with 0x3C, start with tx_data=0xA5 → 8 rise/8 fall edges; mosi reads 1,0,1,0,0,1,0,1 at falls; done at E0+72; rx_data=0x3C; slave holds 0xA5.
- Back-to-back: start held high with tx_data=0x0F immediately after the previous done → new transfer accepted the edge after done; rx_data=0xA5; slave holds 0x0F.
- Ignored inputs: pulse start and change tx_data to 0xFF mid-transfer → only one transfer occurs; slave receives the originally captured word; exactly one done pulse.
- Abort: assert nreset=0 for one edge after the 3rd falling edge → all outputs reach reset values on that edge, no done pulse; a following transfer of 0x81 completes normally in 72 cycles.
- Parameters N=16, HALF=6: tx_data=0x1234, slave preloaded 0xBEEF → 16 edge pairs, done at E0+204, rx_data=0xBEEF.
